// File: rtl/fantasticfft_pkg.sv
// Shared types and constants for the fantasticfft FFT8 blocks.
//   fixed_t            - Q8.8 fixed-point word
//   fft8_frame_t       - one frame of FFT_POINTS words
//   fft8_ctrl_state_e  - frame controller states
package fantasticfft_pkg;

    localparam int unsigned FFT_POINTS   = 8;
    localparam int unsigned FP_INT_BITS  = 8;
    localparam int unsigned FP_FRAC_BITS = 8;

    typedef logic [FP_INT_BITS-1:-FP_FRAC_BITS] fixed_t;

    typedef fixed_t fft8_frame_t [FFT_POINTS];

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DRAIN  = 2'd3
    } fft8_ctrl_state_e;

endpackage

// File: rtl/fft8_result_buffer.sv
// Captures the eight complex FFT8 results and presents the bin picked by sel_i.
// Ports:
//   clk_i, rst_i      - clock, synchronous active-high reset
//   capture_i         - load y_re_i / y_im_i into the buffer
//   y_re_i, y_im_i    - packed result words, element k at [k*W +: W]
//   sel_i             - bin index to present
//   bin_re_o/bin_im_o - selected bin (driven from registers only)
module fft8_result_buffer
    import fantasticfft_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    capture_i,
    input  logic [FFT_POINTS*W-1:0] y_re_i,
    input  logic [FFT_POINTS*W-1:0] y_im_i,
    input  logic [2:0]              sel_i,
    output logic [W-1:0]            bin_re_o,
    output logic [W-1:0]            bin_im_o
);

    logic [W-1:0] re_q [FFT_POINTS];
    logic [W-1:0] im_q [FFT_POINTS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < FFT_POINTS; k++) begin
                re_q[k] <= '0;
                im_q[k] <= '0;
            end
        end else if (capture_i) begin
            for (int k = 0; k < FFT_POINTS; k++) begin
                re_q[k] <= y_re_i[k*W +: W];
                im_q[k] <= y_im_i[k*W +: W];
            end
        end
    end

    assign bin_re_o = re_q[sel_i];
    assign bin_im_o = im_q[sel_i];

endmodule

// File: rtl/fft8_frame_controller.sv
// Frame sequencer for the FFT8 core: gathers eight Q8.8 samples, pulses the
// core start, waits for its result and streams the eight bins out.
// Optional feature macro: FFT8_CTRL_TIMEOUT_EN enables the launch-to-result
// timeout (counter, timeout_err). Undefined: WAIT has no time limit.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   in_data/in_valid/in_ready   - sample input stream
//   fft_x, fft_start            - frame and start pulse to the core
//   fft_result_valid, fft_y(_i) - result from the core
//   out_re/out_im/out_idx/out_valid/out_ready/out_last - bin output stream
//   busy, timeout_err, frames_done - status
module fft8_frame_controller
    import fantasticfft_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 10,
    parameter int unsigned INT_BITS       = 8,
    parameter int unsigned FRAC_BITS      = 8,
    localparam int unsigned W             = INT_BITS + FRAC_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [W-1:0]            in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [FFT_POINTS*W-1:0] fft_x,
    output logic                    fft_start,
    input  logic                    fft_result_valid,
    input  logic [FFT_POINTS*W-1:0] fft_y,
    input  logic [FFT_POINTS*W-1:0] fft_y_i,
    output logic [W-1:0]            out_re,
    output logic [W-1:0]            out_im,
    output logic [2:0]              out_idx,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy,
    output logic                    timeout_err,
    output logic [15:0]             frames_done
);

    fft8_ctrl_state_e state_q, state_d;
    logic [2:0]       wr_idx_q, wr_idx_d;
    logic [2:0]       rd_idx_q, rd_idx_d;
    logic [W-1:0]     frame_q [FFT_POINTS];
    logic [W-1:0]     frame_d [FFT_POINTS];
    logic [15:0]      frames_done_q, frames_done_d;
    logic             in_ready_q, fft_start_q, busy_q, out_valid_q;
    logic             capture;
    logic [W-1:0]     bin_re, bin_im;

`ifdef FFT8_CTRL_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d       = state_q;
        wr_idx_d      = wr_idx_q;
        rd_idx_d      = rd_idx_q;
        frame_d       = frame_q;
        frames_done_d = frames_done_q;
        capture       = 1'b0;
`ifdef FFT8_CTRL_TIMEOUT_EN
        cnt_d         = cnt_q;
        timeout_d     = 1'b0;
`endif
        unique case (state_q)
            FILL: begin
                if (in_valid && in_ready_q) begin
                    frame_d[wr_idx_q] = in_data;
                    wr_idx_d          = wr_idx_q + 3'd1;
                    if (wr_idx_q == 3'd7) state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                // Frame is held through the start cycle, then zeroed for WAIT.
                frame_d = '{default: '0};
`ifdef FFT8_CTRL_TIMEOUT_EN
                // Counter holds cycles elapsed since the start pulse.
                cnt_d   = CntW'(1);
`endif
                state_d = WAIT;
            end
            WAIT: begin
                if (fft_result_valid) begin
                    capture  = 1'b1;
                    rd_idx_d = 3'd0;
                    state_d  = DRAIN;
                end
`ifdef FFT8_CTRL_TIMEOUT_EN
                // Abandon one cycle early so the registered error pulse lands
                // exactly TIMEOUT_CYCLES after the start pulse.
                else if (32'(cnt_q) + 32'd1 >= TIMEOUT_CYCLES) begin
                    timeout_d = 1'b1;
                    wr_idx_d  = 3'd0;
                    state_d   = FILL;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
`endif
            end
            DRAIN: begin
                if (out_valid_q && out_ready) begin
                    rd_idx_d = rd_idx_q + 3'd1;
                    if (rd_idx_q == 3'd7) begin
                        frames_done_d = frames_done_q + 16'd1;
                        wr_idx_d      = 3'd0;
                        state_d       = FILL;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FILL;
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            frame_q       <= '{default: '0};
            frames_done_q <= '0;
            in_ready_q    <= 1'b0;
            fft_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_idx_q      <= wr_idx_d;
            rd_idx_q      <= rd_idx_d;
            frame_q       <= frame_d;
            frames_done_q <= frames_done_d;
            in_ready_q    <= (state_d == FILL);
            fft_start_q   <= (state_d == LAUNCH);
            busy_q        <= (state_d != FILL);
            out_valid_q   <= (state_d == DRAIN);
        end
    end

`ifdef FFT8_CTRL_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    fft8_result_buffer #(
        .W (W)
    ) u_result_buffer (
        .clk_i     (clk),
        .rst_i     (rst),
        .capture_i (capture),
        .y_re_i    (fft_y),
        .y_im_i    (fft_y_i),
        .sel_i     (rd_idx_q),
        .bin_re_o  (bin_re),
        .bin_im_o  (bin_im)
    );

    for (genvar k = 0; k < FFT_POINTS; k++) begin : g_pack_x
        assign fft_x[k*W +: W] = frame_q[k];
    end

    assign in_ready    = in_ready_q;
    assign fft_start   = fft_start_q;
    assign busy        = busy_q;
    assign out_valid   = out_valid_q;
    assign out_idx     = rd_idx_q;
    assign out_last    = out_valid_q && (rd_idx_q == 3'd7);
    assign out_re      = out_valid_q ? bin_re : '0;
    assign out_im      = out_valid_q ? bin_im : '0;
    assign frames_done = frames_done_q;

endmodule

// File: tb/tb_fft8_frame_controller.sv
// Randomized self-checking bench for fft8_frame_controller. The bench plays the
// sample source, a model FFT core with chosen latency and the output sink.
module tb_fft8_frame_controller;

    localparam int unsigned TO = 10;
    localparam int unsigned W  = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   in_data;
    logic           in_valid;
    logic           in_ready;
    logic [8*W-1:0] fft_x;
    logic           fft_start;
    logic           fft_result_valid;
    logic [8*W-1:0] fft_y;
    logic [8*W-1:0] fft_y_i;
    logic [W-1:0]   out_re;
    logic [W-1:0]   out_im;
    logic [2:0]     out_idx;
    logic           out_valid;
    logic           out_ready;
    logic           out_last;
    logic           busy;
    logic           timeout_err;
    logic [15:0]    frames_done;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [15:0] frames_exp = '0;

    always #5 clk = ~clk;

    fft8_frame_controller #(
        .TIMEOUT_CYCLES (TO),
        .INT_BITS       (8),
        .FRAC_BITS      (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .fft_x            (fft_x),
        .fft_start        (fft_start),
        .fft_result_valid (fft_result_valid),
        .fft_y            (fft_y),
        .fft_y_i          (fft_y_i),
        .out_re           (out_re),
        .out_im           (out_im),
        .out_idx          (out_idx),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_last         (out_last),
        .busy             (busy),
        .timeout_err      (timeout_err),
        .frames_done      (frames_done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Result-valid and result words outside WAIT must have no effect.
    task automatic drive_noise();
        fft_result_valid = 1'($urandom_range(0, 1));
        for (int k = 0; k < 8; k++) begin
            fft_y[k*W +: W]   = 16'($urandom);
            fft_y_i[k*W +: W] = 16'($urandom);
        end
    endtask

    task automatic check_reset_vals();
        check_val("rst_fft_x",       32'(fft_x != '0), 32'd0);
        check_val("rst_fft_start",   32'(fft_start), 32'd0);
        check_val("rst_in_ready",    32'(in_ready), 32'd0);
        check_val("rst_out_valid",   32'(out_valid), 32'd0);
        check_val("rst_out_re",      32'(out_re), 32'd0);
        check_val("rst_out_im",      32'(out_im), 32'd0);
        check_val("rst_out_idx",     32'(out_idx), 32'd0);
        check_val("rst_out_last",    32'(out_last), 32'd0);
        check_val("rst_busy",        32'(busy), 32'd0);
        check_val("rst_timeout_err", 32'(timeout_err), 32'd0);
        check_val("rst_frames_done", 32'(frames_done), 32'd0);
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        in_valid         = 1'b0;
        fft_result_valid = 1'b0;
        out_ready        = 1'b0;
        step();
        check_reset_vals();
        rst        = 1'b0;
        frames_exp = '0;
    endtask

    // lat: cycles from the start-pulse cycle to the result-valid cycle.
    // rdy_mode: 0 always ready, 1 pattern 1,0,0, 2 random.
    // rst_fill / rst_bin: reset after that many samples / handshakes (8 = never).
    task automatic run_frame(input int lat, input bit respond, input int rdy_mode,
                             input int rst_fill, input int rst_bin, input bit basic);
        logic [W-1:0] s  [8];
        logic [W-1:0] er [8];
        logic [W-1:0] ei [8];
        logic [W-1:0] sum;
        int           guard;
        int           idx;
        int           start_cyc;

        sum = '0;
        for (int i = 0; i < 8; i++) begin
            s[i] = basic ? 16'((i + 1) << 8) : 16'($urandom);
            sum  = sum + s[i];
        end
        // Model core: bin 0 is the DC sum of the frame, other bins arbitrary.
        er[0] = sum;
        ei[0] = '0;
        for (int k = 1; k < 8; k++) begin
            er[k] = 16'($urandom);
            ei[k] = 16'($urandom);
        end

        for (int i = 0; i < 8; i++) begin
            if (i == rst_fill) begin
                do_reset();
                return;
            end
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                in_valid = 1'b0;
                in_data  = 16'($urandom);
                drive_noise();
                step();
            end
            in_valid = 1'b1;
            in_data  = s[i];
            drive_noise();
            guard = 0;
            while (in_ready !== 1'b1 && guard < 20) begin
                step();
                guard++;
            end
            if (guard >= 20) begin
                check_val("in_ready_wait", 32'(in_ready), 32'd1);
                in_valid = 1'b0;
                return;
            end
            step();
        end
        in_valid         = 1'b0;
        fft_result_valid = 1'b0;

        check_val("start_pulse", 32'(fft_start), 32'd1);
        for (int k = 0; k < 8; k++) check_val("fft_x_launch", 32'(fft_x[k*W +: W]), 32'(s[k]));
        check_val("in_ready_launch", 32'(in_ready), 32'd0);
        check_val("busy_launch", 32'(busy), 32'd1);
        start_cyc = cyc;
        step();
        check_val("start_one_cycle", 32'(fft_start), 32'd0);
        check_val("fft_x_wait_zero", 32'(fft_x != '0), 32'd0);

        if (respond) begin
            while (cyc < start_cyc + lat) begin
                check_val("wait_no_timeout", 32'(timeout_err), 32'd0);
                check_val("wait_busy", 32'(busy), 32'd1);
                step();
            end
            fft_result_valid = 1'b1;
            for (int k = 0; k < 8; k++) begin
                fft_y[k*W +: W]   = er[k];
                fft_y_i[k*W +: W] = ei[k];
            end
            check_val("wait_no_timeout", 32'(timeout_err), 32'd0);
            step();
            fft_result_valid = 1'b0;
            check_val("bin0_latency", 32'(out_valid), 32'd1);
            check_val("no_timeout_capture", 32'(timeout_err), 32'd0);
        end
`ifdef FFT8_CTRL_TIMEOUT_EN
        else begin
            guard = 0;
            while (timeout_err !== 1'b1 && guard < int'(3 * TO)) begin
                step();
                guard++;
            end
            check_val("timeout_latency", 32'(cyc - start_cyc), 32'(TO));
            check_val("timeout_back_to_fill", 32'(in_ready), 32'd1);
            check_val("timeout_busy", 32'(busy), 32'd0);
            check_val("timeout_frames_done", 32'(frames_done), 32'(frames_exp));
            step();
            check_val("timeout_pulse_width", 32'(timeout_err), 32'd0);
            return;
        end
`endif

        idx   = 0;
        guard = 0;
        while (idx < 8 && guard < 100) begin
            if (idx == rst_bin) begin
                do_reset();
                return;
            end
            unique case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (guard % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            drive_noise();
            check_val("drain_valid", 32'(out_valid), 32'd1);
            check_val("drain_idx", 32'(out_idx), 32'(idx));
            check_val("drain_re", 32'(out_re), 32'(er[idx]));
            check_val("drain_im", 32'(out_im), 32'(ei[idx]));
            check_val("drain_last", 32'(out_last), 32'(idx == 7));
            check_val("drain_in_ready", 32'(in_ready), 32'd0);
            if (basic && idx == 0) begin
                check_val("basic_bin0_re", 32'(out_re), 32'h2400);
                check_val("basic_bin0_im", 32'(out_im), 32'h0000);
            end
            step();
            if (out_ready) idx++;
            guard++;
        end
        out_ready        = 1'b0;
        fft_result_valid = 1'b0;
        if (guard >= 100) check_val("drain_budget", 32'(idx), 32'd8);
        frames_exp = frames_exp + 16'd1;
        check_val("post_drain_valid", 32'(out_valid), 32'd0);
        check_val("post_drain_last", 32'(out_last), 32'd0);
        check_val("frames_done", 32'(frames_done), 32'(frames_exp));
        check_val("post_drain_in_ready", 32'(in_ready), 32'd1);
        check_val("post_drain_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int max_lat;
`ifdef FFT8_CTRL_TIMEOUT_EN
        max_lat = TO - 1;
`else
        max_lat = 12;
`endif
        rst              = 1'b1;
        in_data          = '0;
        in_valid         = 1'b0;
        fft_result_valid = 1'b0;
        fft_y            = '0;
        fft_y_i          = '0;
        out_ready        = 1'b0;
        step();
        do_reset();
        step();
        check_val("in_ready_after_rst", 32'(in_ready), 32'd1);

        run_frame(3, 1'b1, 0, 8, 8, 1'b1);
        for (int i = 0; i < 3; i++) run_frame($urandom_range(1, max_lat), 1'b1, 1, 8, 8, 1'b0);
        for (int i = 0; i < 6; i++) run_frame($urandom_range(1, max_lat), 1'b1, 2, 8, 8, 1'b0);

`ifdef FFT8_CTRL_TIMEOUT_EN
        run_frame(1, 1'b0, 0, 8, 8, 1'b0);
        run_frame(TO - 1, 1'b1, 2, 8, 8, 1'b0);
        run_frame(2, 1'b1, 0, 8, 8, 1'b0);
`else
        run_frame(3 * TO, 1'b1, 2, 8, 8, 1'b0);
`endif

        run_frame(3, 1'b1, 0, 5, 8, 1'b0);
        run_frame($urandom_range(1, max_lat), 1'b1, 0, 8, 8, 1'b0);
        run_frame(2, 1'b1, 2, 8, 3, 1'b0);
        run_frame($urandom_range(1, max_lat), 1'b1, 2, 8, 8, 1'b0);

        force dut.frames_done_q = 16'hffff;
        step();
        release dut.frames_done_q;
        frames_exp = 16'hffff;
        check_val("preload_frames_done", 32'(frames_done), 32'(frames_exp));
        run_frame(2, 1'b1, 0, 8, 8, 1'b0);
        run_frame(2, 1'b1, 0, 8, 8, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
